// File: rtl/winddir_seq.sv
// Measurement sequencer for the four-transducer wind sensor: burst, settle,
// acquisition window with sample strobes, then gap, once per transducer.
module winddir_seq #(
    parameter int TXHALF   = 125,
    parameter int BURSTLEN = 8,
    parameter int SETTLE   = 200,
    parameter int SPER     = 100,
    parameter int NSAMP    = 64,
    parameter int GAP      = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       cont,
    input  logic       abort,
    output logic [3:0] tx,
    output logic       txen,
    output logic       endata,
    output logic [1:0] shot,
    output logic       acq,
    output logic       busy,
    output logic       cycdone,
    output logic       overrun
);

    localparam logic [15:0] TXHALF_C = 16'(TXHALF);
    localparam logic [15:0] TXPER_C  = 16'(2 * TXHALF);
    localparam logic [15:0] BURST_C  = 16'(2 * BURSTLEN * TXHALF);
    localparam logic [15:0] SETTLE_C = 16'(SETTLE);
    localparam logic [15:0] SPER_C   = 16'(SPER);
    localparam logic [15:0] ACQ_C    = 16'(NSAMP * SPER);
    localparam logic [15:0] GAP_C    = 16'(GAP);

    typedef enum logic [2:0] {S_IDLE, S_BURST, S_SETTLE, S_ACQ, S_GAP} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  shot_q, shot_d;
    logic        ovr_q, ovr_d;
    logic [3:0]  tx_q, tx_d;
    logic        txen_q, txen_d;
    logic        endata_q, endata_d;
    logic        acq_q, acq_d;
    logic        busy_q, busy_d;
    logic        cycdone_q, cycdone_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shot_q    <= '0;
            ovr_q     <= 1'b0;
            tx_q      <= '0;
            txen_q    <= 1'b0;
            endata_q  <= 1'b0;
            acq_q     <= 1'b0;
            busy_q    <= 1'b0;
            cycdone_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shot_q    <= shot_d;
            ovr_q     <= ovr_d;
            tx_q      <= tx_d;
            txen_q    <= txen_d;
            endata_q  <= endata_d;
            acq_q     <= acq_d;
            busy_q    <= busy_d;
            cycdone_q <= cycdone_d;
        end
    end

    // Phase counter restarts at zero on every state entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        shot_d  = shot_q;
        ovr_d   = ovr_q;
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            shot_d  = '0;
        end else begin
            if (start && state_q != S_IDLE) begin
                ovr_d = 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (start) begin
                        state_d = S_BURST;
                        ovr_d   = 1'b0;
                    end
                end
                S_BURST: begin
                    if (cnt_q == BURST_C - 16'd1) begin
                        state_d = S_SETTLE;
                        cnt_d   = '0;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == SETTLE_C - 16'd1) begin
                        state_d = S_ACQ;
                        cnt_d   = '0;
                    end
                end
                S_ACQ: begin
                    if (cnt_q == ACQ_C - 16'd1) begin
                        state_d = S_GAP;
                        cnt_d   = '0;
                    end
                end
                S_GAP: begin
                    if (cnt_q == GAP_C - 16'd1) begin
                        cnt_d = '0;
                        if (shot_q == 2'd3) begin
                            shot_d  = '0;
                            state_d = cont ? S_BURST : S_IDLE;
                        end else begin
                            shot_d  = shot_q + 2'd1;
                            state_d = S_BURST;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the upcoming state so they register in step with it.
    always_comb begin
        tx_d      = '0;
        txen_d    = 1'b0;
        endata_d  = 1'b0;
        acq_d     = 1'b0;
        busy_d    = (state_d != S_IDLE);
        cycdone_d = 1'b0;
        case (state_d)
            S_BURST: begin
                txen_d = 1'b1;
                if ((cnt_d % TXPER_C) < TXHALF_C) begin
                    tx_d[shot_d] = 1'b1;
                end
            end
            S_ACQ: begin
                acq_d    = 1'b1;
                endata_d = ((cnt_d % SPER_C) == 16'd0);
            end
            S_GAP: begin
                cycdone_d = (cnt_d == GAP_C - 16'd1) && (shot_d == 2'd3);
            end
            default: ;
        endcase
    end

    assign tx      = tx_q;
    assign txen    = txen_q;
    assign endata  = endata_q;
    assign shot    = shot_q;
    assign acq     = acq_q;
    assign busy    = busy_q;
    assign cycdone = cycdone_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_winddir_seq.sv
// Bench for winddir_seq: directed scenarios then random traffic, all checked
// every cycle against a time-position model of the four-shot measurement cycle.
module tb_winddir_seq;

    localparam int TXHALF   = 2;
    localparam int BURSTLEN = 2;
    localparam int SETTLE   = 3;
    localparam int SPER     = 4;
    localparam int NSAMP    = 3;
    localparam int GAP      = 5;
    localparam int BURST_C  = 2 * BURSTLEN * TXHALF;
    localparam int ACQ_C    = NSAMP * SPER;
    localparam int SHOT_C   = BURST_C + SETTLE + ACQ_C + GAP;
    localparam int CYC_C    = 4 * SHOT_C;

    logic       clock, reset, start, cont, abort;
    logic [3:0] tx;
    logic       txen, endata, acq, busy, cycdone, overrun;
    logic [1:0] shot;

    int nchk  = 0;
    int nfail = 0;

    // Reference: running flag, position within the 4-shot cycle, sticky overrun.
    bit   m_run = 1'b0;
    int   m_t   = 0;
    logic m_ovr = 1'b0;

    winddir_seq #(
        .TXHALF(TXHALF), .BURSTLEN(BURSTLEN), .SETTLE(SETTLE),
        .SPER(SPER), .NSAMP(NSAMP), .GAP(GAP)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .cont(cont), .abort(abort),
        .tx(tx), .txen(txen), .endata(endata), .shot(shot), .acq(acq),
        .busy(busy), .cycdone(cycdone), .overrun(overrun)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        if (!reset) begin
            m_run = 1'b0; m_t = 0; m_ovr = 1'b0;
        end else if (abort) begin
            m_run = 1'b0; m_t = 0;
        end else if (!m_run) begin
            if (start) begin
                m_run = 1'b1; m_t = 0; m_ovr = 1'b0;
            end
        end else begin
            if (start) m_ovr = 1'b1;
            if (m_t == CYC_C - 1) begin
                m_t = 0;
                if (!cont) m_run = 1'b0;
            end else begin
                m_t++;
            end
        end
    endtask

    task automatic check_outputs();
        int s, p;
        logic [3:0] etx;
        logic [1:0] esh;
        logic etxen, een, eacq, ecd;
        etx = '0; esh = '0; etxen = 0; een = 0; eacq = 0; ecd = 0;
        if (m_run) begin
            s   = m_t / SHOT_C;
            p   = m_t % SHOT_C;
            esh = 2'(s);
            if (p < BURST_C) begin
                etxen = 1'b1;
                if ((p % (2 * TXHALF)) < TXHALF) etx[s] = 1'b1;
            end else if (p >= BURST_C + SETTLE && p < BURST_C + SETTLE + ACQ_C) begin
                eacq = 1'b1;
                een  = ((p - BURST_C - SETTLE) % SPER) == 0;
            end
            ecd = (m_t == CYC_C - 1);
        end
        chk("tx", tx, etx);
        chk("txen", {3'b000, txen}, {3'b000, etxen});
        chk("endata", {3'b000, endata}, {3'b000, een});
        chk("shot", {2'b00, shot}, {2'b00, esh});
        chk("acq", {3'b000, acq}, {3'b000, eacq});
        chk("busy", {3'b000, busy}, {3'b000, m_run});
        chk("cycdone", {3'b000, cycdone}, {3'b000, ecd});
        chk("overrun", {3'b000, overrun}, {3'b000, m_ovr});
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        check_outputs();
    endtask

    // cont only matters on the last cycle of a lap; elsewhere it is noise.
    task automatic set_cont(input logic forced);
        if (m_run && m_t == CYC_C - 1) cont = forced;
        else cont = 1'($urandom_range(0, 1));
    endtask

    initial begin
        clock = 0; reset = 0; start = 1; cont = 0; abort = 0;

        // Reset held with start asserted
        repeat (3) tick();
        chk("rst_busy", {3'b000, busy}, 4'd0);
        reset = 1; start = 0;
        tick();

        // Single cycle, cont=0 at the decision point
        start = 1; set_cont(1'b0); tick(); start = 0;
        chk("single_tx0_c1", {3'b000, tx[0]}, 4'd1);
        for (int c = 2; c <= 115; c++) begin
            set_cont(1'b0);
            tick();
            if (c == 3)   chk("single_tx0_c3", {3'b000, tx[0]}, 4'd0);
            if (c == 12)  chk("single_endata_c12", {3'b000, endata}, 4'd1);
            if (c == 29)  chk("single_shot_c29", {2'b00, shot}, 4'd1);
            if (c == 85)  chk("single_shot_c85", {2'b00, shot}, 4'd3);
            if (c == 112) chk("single_cycdone_c112", {3'b000, cycdone}, 4'd1);
            if (c == 113) chk("single_busy_c113", {3'b000, busy}, 4'd0);
        end

        // Continuous: one wrap, then stop at the end of the second lap
        start = 1; set_cont(1'b1); tick(); start = 0;
        for (int c = 2; c <= 113; c++) begin
            set_cont(1'b1);
            tick();
            if (c == 112) chk("cont_cycdone_c112", {3'b000, cycdone}, 4'd1);
            if (c == 113) begin
                chk("cont_shot_c113", {2'b00, shot}, 4'd0);
                chk("cont_tx0_c113", {3'b000, tx[0]}, 4'd1);
                chk("cont_busy_c113", {3'b000, busy}, 4'd1);
            end
        end
        for (int c = 0; c < 115; c++) begin
            set_cont(1'b0);
            tick();
        end
        chk("cont_end_busy", {3'b000, busy}, 4'd0);

        // Overrun: start during ACQ on cycle 14
        start = 1; set_cont(1'b0); tick(); start = 0;
        for (int c = 2; c <= 14; c++) begin
            set_cont(1'b0);
            tick();
        end
        start = 1; set_cont(1'b0); tick(); start = 0;
        chk("ovr_set_c15", {3'b000, overrun}, 4'd1);
        for (int c = 16; c <= 116; c++) begin
            set_cont(1'b0);
            tick();
            if (c == 16) chk("ovr_endata_c16", {3'b000, endata}, 4'd1);
        end
        chk("ovr_sticky_idle", {3'b000, overrun}, 4'd1);
        start = 1; set_cont(1'b0); tick(); start = 0;
        chk("ovr_cleared", {3'b000, overrun}, 4'd0);

        // Abort mid-burst of shot 2 (the start above is cycle 1)
        for (int c = 2; c <= 60; c++) begin
            set_cont(1'b0);
            tick();
        end
        chk("abort_shot_c60", {2'b00, shot}, 4'd2);
        abort = 1; tick(); abort = 0;
        chk("abort_tx", tx, 4'd0);
        chk("abort_shot", {2'b00, shot}, 4'd0);
        chk("abort_busy", {3'b000, busy}, 4'd0);
        repeat (3) tick();
        start = 1; tick(); start = 0;
        chk("abort_restart_tx", tx, 4'b0001);
        abort = 1; tick(); abort = 0;

        // Simultaneous start and abort in IDLE
        start = 1; abort = 1; tick();
        chk("sa_busy", {3'b000, busy}, 4'd0);
        chk("sa_overrun", {3'b000, overrun}, 4'd0);
        start = 0; abort = 0; tick();

        // Random traffic including mid-run resets and aborts
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 39) == 0);
            abort = ($urandom_range(0, 299) == 0);
            reset = ($urandom_range(0, 499) != 0);
            cont  = 1'($urandom_range(0, 1));
            tick();
        end

        $display("%0d/%0d checks passed", nchk - nfail, nchk);
        $finish;
    end

endmodule

// File: doc/winddir_seq.md
# winddir_seq

Measurement sequencer for the four-transducer wind sensor. It fires an ultrasonic burst from each transducer in turn, waits for the echo to settle, and opens an acquisition window. During that window it generates the `endata` sample strobe that clocks `rx1..rx4` into `winddir`. It sits between the system control logic (start, continuous mode, abort) and the transducer drivers and ADC-facing datapath.

## Interface
Parameters:
- `TXHALF`, 125: clocks per half period of the burst square wave (400 kHz at 100 MHz).
- `BURSTLEN`, 8: square-wave periods per burst.
- `SETTLE`, 200: clocks between burst end and acquisition start.
- `SPER`, 100: clocks per sample slot. This is the `endata` period.
- `NSAMP`, 64: samples (strobes) per acquisition window.
- `GAP`, 1000: idle clocks after each window.
- All derived counts must fit in 16 bits.

Ports:
- `clock` in 1: single system clock. Rising edge.
- `reset` in 1: synchronous, active-low. When low at an edge, all state and outputs are cleared.
- `start` in 1: level sampled each edge. Accepted only in IDLE.
- `cont` in 1: continuous mode. Sampled only at the end of shot 3.
- `abort` in 1: returns the block to IDLE. Highest priority after reset.
- `tx` out 4: one-hot burst drive. `tx[shot]` toggles during BURST.
- `txen` out 1: high throughout BURST.
- `endata` out 1: one-clock sample strobe to `winddir`.
- `shot` out 2: current transducer index, 0..3.
- `acq` out 1: high throughout ACQ.
- `busy` out 1: high in every state except IDLE.
- `cycdone` out 1: one-clock pulse when a four-shot cycle completes.
- `overrun` out 1: sticky flag. Set when `start` arrives while busy.

## Operation
States: IDLE, BURST, SETTLE, ACQ, GAP. A single 16-bit phase counter is cleared on every state entry.
- **Reset:** state IDLE, `shot`=0, all outputs 0.
- **IDLE:** if `start`=1 and `abort`=0, go to BURST and clear `overrun`.
- **BURST:** lasts 2·BURSTLEN·TXHALF cycles.
  - `tx[shot]`=1 for the first TXHALF cycles of each period and 0 for the second TXHALF.
  - All other `tx` bits are 0.
  - Then go to SETTLE.
- **SETTLE:** lasts SETTLE cycles with `tx`=0. Then go to ACQ.
- **ACQ:** lasts NSAMP·SPER cycles.
  - `endata`=1 in the first cycle of each SPER-cycle slot, giving exactly NSAMP strobes.
  - The first strobe falls on the first ACQ cycle.
  - Then go to GAP.
- **GAP:** lasts GAP cycles. On its final cycle:
  - If `shot`<3: increment `shot` and go to BURST.
  - If `shot`=3: assert `cycdone` for that cycle and wrap `shot` to 0. Go to BURST if `cont`=1, otherwise go to IDLE.
- **Abort:** `abort`=1 in any state gives IDLE at the next edge.
  - `tx`, `txen`, `acq`, `endata` and `busy` go to 0; `shot` goes to 0.
  - No `cycdone` pulse.
  - `overrun` is unchanged.
- **Start while busy:** `start`=1 in a non-IDLE state with `abort`=0 sets `overrun`=1 at the next edge. Sequencing is unaffected.
- **Start with abort:** `start` and `abort` in the same cycle resolve to abort. `start` is ignored and `overrun` is not set.
- **`cont` sampling:** changes to `cont` are ignored except on the final GAP cycle of shot 3.

## Timing
- All outputs are registered. Each asserts on the first cycle of its state and deasserts on the cycle after that state's last cycle.
- A start accepted at edge N puts the block in BURST from cycle N+1: `tx[0]`=1 and `txen`=1.
- Per-shot length is 2·BURSTLEN·TXHALF + SETTLE + NSAMP·SPER + GAP cycles. With defaults this is 9600 cycles, or 38400 cycles per cycle of four shots.
- In continuous mode there is no dead cycle between shot 3 GAP and the next shot 0 BURST.
- `endata` never asserts outside ACQ. The spacing between strobes is exactly SPER.
- When `reset` goes low mid-operation, all outputs are 0 from the next edge, with no partial burst or strobe.

## Test plan
All scenarios use TXHALF=2, BURSTLEN=2, SETTLE=3, SPER=4, NSAMP=3, GAP=5. This gives 28 cycles per shot and 112 per cycle. Cycle 1 is the first cycle after `start` is accepted.

- **Reset:** `reset`=0 for 3 edges with `start`=1 -> all outputs 0 and `busy`=0. After release, the next `start` is accepted.
- **Single cycle:**
  - Stimulus: `start` pulse with `cont`=0.
  - `tx[0]` pattern over cycles 1–8 is 1,1,0,0,1,1,0,0.
  - `endata` is high on cycles 12, 16 and 20; `acq` is high on cycles 12–23.
  - `shot` steps to 1, 2 and 3 at cycles 29, 57 and 85.
  - `cycdone` is high on cycle 112; `busy`=0 from cycle 113.
- **Continuous:** `cont`=1 -> `cycdone` on cycle 112, then `shot`=0 and `tx[0]`=1 on cycle 113, and `busy` stays 1.
- **Overrun:**
  - Stimulus: `start` on cycle 14 (during ACQ).
  - `overrun`=1 from cycle 15 onward, with strobe timing unchanged.
  - `overrun` is cleared by the next `start` accepted in IDLE.
- **Abort mid-burst:**
  - Stimulus: `abort` at cycle 60 (shot 2 BURST).
  - From cycle 61: `tx`=0, `shot`=0, `busy`=0, and there is no `cycdone`.
  - A following `start` begins with `tx[0]`.
- **Simultaneous start and abort:** both asserted in IDLE -> the block stays in IDLE, `busy`=0 and `overrun`=0.
